// File: rtl/csa_reduce_pkg.sv
// Shared constants for the carry-save reduce/accumulate pipe.
// Depth and output width are derived from the operand geometry.
package csa_reduce_pkg;

  // Number of registered 4:2 levels needed to reduce n operands to a pair.
  function automatic int levels_f(input int n);
    return $clog2(n) - 1;
  endfunction

  // Output pair width: operand bits, tree growth and accumulation guard.
  function automatic int out_w_f(input int w, input int n, input int e);
    return w + $clog2(n) + e;
  endfunction

endpackage

// File: rtl/csa_row_4_2.sv
// Combinational row of 4:2 compressors, W bits wide, modulo 2^W.
// Ports: in_0..in_3 addends; out_0 sum vector, out_1 weight-aligned carry.
module csa_row_4_2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] in_0,
  input  logic [W-1:0] in_1,
  input  logic [W-1:0] in_2,
  input  logic [W-1:0] in_3,
  output logic [W-1:0] out_0,
  output logic [W-1:0] out_1
);

  logic [W-1:0] s1;
  logic [W-1:0] co;
  logic [W-1:0] ci;
  logic [W-1:0] c2;

  // cout depends only on in_0..in_2, so the cout->cin chain never ripples.
  assign s1 = in_0 ^ in_1 ^ in_2;
  assign co = (in_0 & in_1) | (in_0 & in_2) | (in_1 & in_2);
  assign ci = co << 1;

  assign out_0 = s1 ^ in_3 ^ ci;
  assign c2    = (s1 & in_3) | (s1 & ci) | (in_3 & ci);
  assign out_1 = c2 << 1;

endmodule

// File: rtl/csa_reduce_acc_pipe.sv
// Pipelined 4:2 reduction tree plus carry-save packet accumulator.
// Ports: in_* beat handshake, out_* packet result (sum/carry pair);
// CSA_REDUCE_FINAL_ADD_EN adds a registered adder and out_result.
module csa_reduce_acc_pipe
  import csa_reduce_pkg::*;
#(
  parameter int WIDTH     = 24,
  parameter int NUM_IN    = 8,
  parameter int ACC_EXTRA = 8,
  localparam int OUT_W    = out_w_f(WIDTH, NUM_IN, ACC_EXTRA)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_sum,
  output logic [OUT_W-1:0]        out_carry
`ifdef CSA_REDUCE_FINAL_ADD_EN
  ,
  output logic [OUT_W-1:0]        out_result
`endif
);

  localparam int LEVELS = levels_f(NUM_IN);
  localparam int VW     = NUM_IN * OUT_W;

  typedef struct packed {
    logic [OUT_W-1:0] sum;
    logic [OUT_W-1:0] carry;
  } cs_pair_t;

  logic [VW-1:0]     ops;
  logic [VW-1:0]     stg [1:LEVELS];
  logic [LEVELS:1]   sv;
  logic [LEVELS:1]   sl;
  logic [LEVELS:1]   adv;
  logic              acc_go;
  logic              res_v;
  logic              res_deq;
  logic              res_free;
  cs_pair_t          acc_q;
  cs_pair_t          res_q;
  logic [OUT_W-1:0]  nx_sum;
  logic [OUT_W-1:0]  nx_carry;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_zext
    assign ops[k*OUT_W +: OUT_W] = OUT_W'(in_data[k*WIDTH +: WIDTH]);
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int NI = NUM_IN >> (l - 1);
    localparam int NR = NI / 4;

    logic [NI*OUT_W-1:0]   src;
    logic [2*NR*OUT_W-1:0] nxt;
    logic                  src_v;
    logic                  src_l;

    if (l == 1) begin : g_first
      assign src   = ops;
      assign src_v = in_valid;
      assign src_l = in_last;
    end else begin : g_next
      assign src   = stg[l-1][NI*OUT_W-1:0];
      assign src_v = sv[l-1];
      assign src_l = sl[l-1];
    end

    for (genvar r = 0; r < NR; r++) begin : g_row
      csa_row_4_2 #(.W(OUT_W)) u_row (
        .in_0  (src[(4*r+0)*OUT_W +: OUT_W]),
        .in_1  (src[(4*r+1)*OUT_W +: OUT_W]),
        .in_2  (src[(4*r+2)*OUT_W +: OUT_W]),
        .in_3  (src[(4*r+3)*OUT_W +: OUT_W]),
        .out_0 (nxt[(2*r+0)*OUT_W +: OUT_W]),
        .out_1 (nxt[(2*r+1)*OUT_W +: OUT_W])
      );
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        sv[l]  <= 1'b0;
        sl[l]  <= 1'b0;
        stg[l] <= '0;
      end else if (adv[l]) begin
        sv[l] <= src_v;
        if (src_v) begin
          sl[l]  <= src_l;
          stg[l] <= VW'(nxt);
        end
      end
    end
  end

  // Ready ripples back from the accumulator; a stage moves if empty
  // or if its successor moves this cycle.
  always_comb begin
    logic go;
    adv = '0;
    go  = acc_go;
    for (int l = LEVELS; l >= 1; l--) begin
      adv[l] = !sv[l] || go;
      go     = adv[l];
    end
  end

  assign in_ready = adv[1];

  csa_row_4_2 #(.W(OUT_W)) u_acc (
    .in_0  (stg[LEVELS][OUT_W-1:0]),
    .in_1  (stg[LEVELS][2*OUT_W-1:OUT_W]),
    .in_2  (acc_q.sum),
    .in_3  (acc_q.carry),
    .out_0 (nx_sum),
    .out_1 (nx_carry)
  );

`ifdef CSA_REDUCE_FINAL_ADD_EN
  logic             fin_v;
  cs_pair_t         fin_q;
  logic [OUT_W-1:0] fin_res;

  assign res_deq = !fin_v || out_ready;
`else
  assign res_deq = out_ready;
`endif

  assign res_free = !res_v || res_deq;
  // Non-last beats always fold into acc; a last beat needs the
  // result register free (or emptying on this edge).
  assign acc_go   = sv[LEVELS] && (!sl[LEVELS] || res_free);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (acc_go) begin
      acc_q <= sl[LEVELS] ? '0 : {nx_sum, nx_carry};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_v <= 1'b0;
      res_q <= '0;
    end else if (acc_go && sl[LEVELS]) begin
      res_v <= 1'b1;
      res_q <= {nx_sum, nx_carry};
    end else if (res_v && res_deq) begin
      res_v <= 1'b0;
    end
  end

`ifdef CSA_REDUCE_FINAL_ADD_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fin_v   <= 1'b0;
      fin_q   <= '0;
      fin_res <= '0;
    end else if (res_deq) begin
      fin_v <= res_v;
      if (res_v) begin
        fin_q   <= res_q;
        fin_res <= res_q.sum + res_q.carry;
      end
    end
  end

  assign out_valid  = fin_v;
  assign out_sum    = fin_q.sum;
  assign out_carry  = fin_q.carry;
  assign out_result = fin_res;
`else
  assign out_valid = res_v;
  assign out_sum   = res_q.sum;
  assign out_carry = res_q.carry;
`endif

endmodule
